spi_slave_gen: RTL and testbench
================================

Name: spi_slave_gen

Overview:
- Parametrised next-generation SPI slave for the SPI-to-single-port-RAM path. Sits between the external SPI master and the RAM wrapper.
- Deserialises command frames of DATA_W+2 bits into rx_data/rx_valid, then serialises the RAM read word onto MISO.
- Changes from the previous generation:
  - width is parametrised;
  - rx_valid is a one-cycle pulse;
  - it adds an explicit read-wait state with a tx timeout, a busy output and a clean abort on SS_n.

Parameters:
- DATA_W, 8, RAM data/address payload width; frame width FRAME_W = DATA_W+2.
- TX_TIMEOUT, 16, max cycles to wait for tx_valid in READ_WAIT (must be ≥1).
- MISO_IDLE, 0, level driven on MISO when not shifting data out.

Ports:
- clk  in  1  system clock; SPI bit rate = one bit per clk.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial in, MSB first.
- MISO  out  1  serial out, MSB first.
- rx_data  out  FRAME_W  received frame; [FRAME_W-1:FRAME_W-2] = cmd, [DATA_W-1:0] = payload.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- tx_data  in  DATA_W  read word from RAM.
- tx_valid  in  1  tx_data valid (sampled only in READ_WAIT).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst_n low asynchronously forces the following, from any state, mid-frame included:
  - state=IDLE;
  - rx_data=0, rx_valid=0, MISO=MISO_IDLE, busy=0;
  - rd_addr_seen=0, shift register and counters=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_OUT, DONE.
- SS_n high in any non-IDLE state:
  - next state IDLE, partial frame discarded, no rx_valid;
  - MISO returns to MISO_IDLE next cycle;
  - rd_addr_seen unchanged.
- IDLE: SS_n low → CHK_CMD.
- CHK_CMD:
  - MOSI is frame bit FRAME_W-1 and is captured into the shift register; bit counter loads FRAME_W-1.
  - MOSI=0 → WRITE.
  - MOSI=1 and rd_addr_seen=0 → READ_ADD.
  - MOSI=1 and rd_addr_seen=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA (shift in):
  - one bit per clk, counter decrements.
  - On the edge that samples the last bit (counter 1→0), rx_data ← full frame and rx_valid=1 for exactly the following cycle.
  - Latency: rx_valid asserts FRAME_W cycles after the CHK_CMD cycle.
  - Next state: WRITE → DONE; READ_ADD → DONE and rd_addr_seen←1; READ_DATA → READ_WAIT.
- READ_WAIT:
  - wait counter counts from 0.
  - tx_valid=1 → load tx_data into out shift register, counter ← DATA_W, go to READ_OUT. tx_valid in the first READ_WAIT cycle is accepted.
  - Wait counter reaches TX_TIMEOUT without tx_valid → DONE; rd_addr_seen cleared; no MISO data.
- READ_OUT:
  - MISO = out_reg[DATA_W-1], shifted left each clk, for DATA_W cycles.
  - First data bit appears on MISO the cycle after tx_valid is accepted.
  - After the last bit: MISO=MISO_IDLE, rd_addr_seen←0, → DONE.
- DONE: MOSI ignored; stay until SS_n high → IDLE. One command per SS_n assertion.
- tx_valid outside READ_WAIT is ignored.
- rx_valid is never asserted in two consecutive cycles.
- Counters are sized $clog2(FRAME_W+1) and $clog2(TX_TIMEOUT+1). No wrap is possible because counting stops at terminal values.

Optional Feature:
- Macro: SPI_SLAVE_GEN_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit) and err_cnt (8 bit, saturating at 255), both reset to 0.
  - frame_err pulses for one cycle on either of:
    - SS_n rising while in WRITE/READ_ADD/READ_DATA/READ_WAIT/READ_OUT;
    - a READ_WAIT timeout.
  - err_cnt increments on each frame_err pulse.
- Undefined: ports and logic absent; aborts and timeouts are silent. All other behaviour identical.

Test Plan:
- DATA_W=8. SS_n low, MOSI frame 00_1010_0101 → rx_data=10'h0A5, rx_valid high for 1 cycle, 10 cycles after CHK_CMD. Then SS_n high → IDLE, busy=0.
- Read sequence:
  - Frame 10_0011_1100 → rx_data=10'h23C, rd_addr_seen=1.
  - New SS_n frame 11_xxxx_xxxx → rx_data=10'h3xx.
  - tx_valid with tx_data=8'h96 two cycles later → MISO 1,0,0,1,0,1,1,0 on the following 8 cycles, then MISO_IDLE.
- Abort: SS_n high after 5 bits of a WRITE frame → no rx_valid, state IDLE next cycle. With the macro: frame_err pulse, err_cnt=1.
- Read data with tx_valid never asserted (TX_TIMEOUT=16) → DONE after 16 READ_WAIT cycles, MISO stays MISO_IDLE, rd_addr_seen=0. Next read frame enters READ_ADD.
- rst_n low for 1 cycle mid READ_OUT (bit 3) → immediately MISO=MISO_IDLE, busy=0, rd_addr_seen=0. After release, frame 01_0000_0001 → rx_data=10'h101.
- Extra MOSI toggling in DONE while SS_n stays low → no further rx_valid until SS_n cycles high/low.

Source files
------------

// File: rtl/spi_slave_gen.sv
// SPI slave for the SPI-to-RAM path: deserialises DATA_W+2 bit command frames
// and serialises the RAM read word back on MISO. Optional SPI_SLAVE_GEN_FRAME_ERR_EN adds frame_err/err_cnt.
module spi_slave_gen #(
    parameter int   DATA_W     = 8,
    parameter int   TX_TIMEOUT = 16,
    parameter logic MISO_IDLE  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy
`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
    ,
    output logic              frame_err,
    output logic [7:0]        err_cnt
`endif
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CW      = $clog2(FRAME_W + 1);
    localparam int WW      = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_OUT, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] sh, sh_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WW-1:0]      wcnt, wcnt_nxt;
    logic [DATA_W-1:0]  out_reg, out_nxt;
    logic [FRAME_W-1:0] rx_data_nxt;
    logic               rx_valid_nxt;
    logic               rd_addr_seen, seen_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sh           <= '0;
            cnt          <= '0;
            wcnt         <= '0;
            out_reg      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            state        <= state_nxt;
            sh           <= sh_nxt;
            cnt          <= cnt_nxt;
            wcnt         <= wcnt_nxt;
            out_reg      <= out_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rd_addr_seen <= seen_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sh_nxt       = sh;
        cnt_nxt      = cnt;
        wcnt_nxt     = wcnt;
        out_nxt      = out_reg;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        seen_nxt     = rd_addr_seen;
        // Deselect aborts everything; rd_addr_seen survives so an address frame stays valid.
        if (state != IDLE && SS_n) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (!SS_n) state_nxt = CHK_CMD;
                CHK_CMD: begin
                    sh_nxt  = FRAME_W'(MOSI);
                    cnt_nxt = CW'(FRAME_W - 1);
                    if (!MOSI)             state_nxt = WRITE;
                    else if (!rd_addr_seen) state_nxt = READ_ADD;
                    else                    state_nxt = READ_DATA;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    sh_nxt  = {sh[FRAME_W-2:0], MOSI};
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        rx_data_nxt  = {sh[FRAME_W-2:0], MOSI};
                        rx_valid_nxt = 1'b1;
                        wcnt_nxt     = '0;
                        case (state)
                            READ_ADD: begin
                                state_nxt = DONE;
                                seen_nxt  = 1'b1;
                            end
                            READ_DATA: state_nxt = READ_WAIT;
                            default:   state_nxt = DONE;
                        endcase
                    end
                end
                READ_WAIT: begin
                    if (tx_valid) begin
                        out_nxt   = tx_data;
                        cnt_nxt   = CW'(DATA_W);
                        state_nxt = READ_OUT;
                    end else if (wcnt == WW'(TX_TIMEOUT - 1)) begin
                        state_nxt = DONE;
                        seen_nxt  = 1'b0;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
                READ_OUT: begin
                    out_nxt = {out_reg[DATA_W-2:0], 1'b0};
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_nxt = DONE;
                        seen_nxt  = 1'b0;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign MISO = (state == READ_OUT) ? out_reg[DATA_W-1] : MISO_IDLE;
    assign busy = (state != IDLE);

`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
    logic err_evt;
    assign err_evt = (SS_n && (state inside {WRITE, READ_ADD, READ_DATA, READ_WAIT, READ_OUT}))
                   || (!SS_n && state == READ_WAIT && !tx_valid && wcnt == WW'(TX_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_err <= err_evt;
            if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_gen.sv
// Randomised scoreboard bench for spi_slave_gen: stimulus pushes expected frames and
// read words; a negedge monitor pops and compares them against rx_valid and MISO.
module tb_spi_slave_gen;
    localparam int   DW   = 8;
    localparam int   FW   = DW + 2;
    localparam int   TOUT = 16;
    localparam logic MI   = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid, busy;
    logic [FW-1:0] rx_data;
    logic [DW-1:0] tx_data;
`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
    logic          frame_err;
    logic [7:0]    err_cnt;
`endif

    spi_slave_gen #(.DATA_W(DW), .TX_TIMEOUT(TOUT), .MISO_IDLE(MI)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy)
`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
        , .frame_err(frame_err), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [FW-1:0] f; int c; } rx_exp_t;
    typedef struct { logic [DW-1:0] w; int s; } tx_exp_t;

    rx_exp_t exp_rx[$];
    tx_exp_t miso_q[$];
    int      cyc = 0;
    int      n_chk = 0;
    int      n_fail = 0;
    int      err_exp = 0;
    logic    seen = 1'b0;
    logic    ro_cancel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations when the DUT presents rx_valid or a read word on MISO.
    initial begin
        tx_exp_t cur;
        rx_exp_t e;
        logic    active;
        int      idx;
        active = 1'b0;
        cur = '{w: '0, s: 0};
        forever begin
            @(negedge clk);
            if (ro_cancel) begin
                active    = 1'b0;
                ro_cancel = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    chk("rx_valid_unexpected", 32'(rx_valid), 32'(0));
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.f));
                    chk("rx_latency", 32'(cyc), 32'(e.c));
                end
            end
            if (!active && miso_q.size() > 0 && cyc >= miso_q[0].s) begin
                cur    = miso_q.pop_front();
                active = 1'b1;
            end
            if (active) begin
                idx = cyc - cur.s;
                if (idx < DW) chk("miso_bit", 32'(MISO), 32'(cur.w[DW-1-idx]));
                else begin
                    chk("miso_end", 32'(MISO), 32'(MI));
                    active = 1'b0;
                end
            end else begin
                chk("miso_idle", 32'(MISO), 32'(MI));
            end
        end
    end

    task automatic tick(input logic ss, input logic mo, input logic tv, input logic [DW-1:0] td);
        @(negedge clk);
        SS_n     = ss;
        MOSI     = mo;
        tx_valid = tv;
        tx_data  = td;
    endtask

    // One full command under one SS_n assertion. k = READ_WAIT cycle index carrying tx_valid.
    task automatic run_frame(input logic [FW-1:0] f, input int k, input logic [DW-1:0] w,
                             input int hold, input int rst_at);
        int   rxc, nt, st;
        logic acc;
        tick(1'b0, 1'b0, 1'b0, '0);
        for (int i = FW - 1; i >= 0; i--) tick(1'b0, f[i], 1'b0, '0);
        rxc = cyc + 1;
        exp_rx.push_back('{f: f, c: rxc});
        acc = 1'b0;
        if (f[FW-1]) begin
            if (!seen) seen = 1'b1;
            else begin
                seen = 1'b0;
                if (k < TOUT) acc = 1'b1;
                else err_exp++;
            end
        end
        st = rxc + k + 1;
        if (acc) miso_q.push_back('{w: w, s: st});
        nt = ((k > TOUT) ? k : TOUT) + DW + 3 + hold;
        for (int j = 0; j < nt; j++) begin
            tick(1'b0, 1'($urandom), (j == k), (j == k) ? w : DW'($urandom));
            if (acc && rst_at >= 0 && cyc == st + rst_at) begin
                #2;
                rst_n     = 1'b0;
                ro_cancel = 1'b1;
                SS_n      = 1'b1;
                tx_valid  = 1'b0;
                #1;
                chk("rst_miso", 32'(MISO), 32'(MI));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_rx_valid", 32'(rx_valid), 32'(0));
                chk("rst_rx_data", 32'(rx_data), 32'(0));
                seen    = 1'b0;
                err_exp = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_busy", 32'(busy), 32'(1));
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    // Deselect after nb bits of a frame: no rx_valid, back to IDLE next cycle.
    task automatic run_partial(input logic [FW-1:0] f, input int nb);
        tick(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < nb; i++) tick(1'b0, f[FW-1-i], 1'b0, '0);
        tick(1'b1, 1'b0, 1'b0, '0);
        if (nb >= 1) err_exp++;
        tick(1'b1, 1'b0, 1'b0, '0);
        chk("abort_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [FW-1:0] f;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rx_data", 32'(rx_data), 32'(0));
        chk("reset_rx_valid", 32'(rx_valid), 32'(0));
        chk("reset_miso", 32'(MISO), 32'(MI));
        chk("reset_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, '0);

        run_frame(10'h0A5, 0, 8'h00, 2, -1);
        run_frame(10'h23C, 0, 8'h00, 0, -1);
        run_frame(10'h3C7, 2, 8'h96, 0, -1);
        run_partial(10'h0AA, 5);
        run_frame(10'h255, 0, 8'h00, 0, -1);
        run_frame(10'h3AA, TOUT + 2, 8'hFF, 0, -1);
        run_frame(10'h211, 3, 8'hC3, 0, -1);
        run_frame(10'h3C3, 1, 8'h5A, 0, 3);
        run_frame(10'h101, 0, 8'h00, 12, -1);
        run_frame(10'h300, TOUT - 1, 8'h81, 0, -1);
        run_frame(10'h3FF, 0, 8'h7E, 3, -1);
        run_frame(10'h3FF, TOUT - 1, 8'hA5, 0, -1);
        run_frame(10'h3FF, TOUT, 8'hA5, 0, -1);

        for (int n = 0; n < 40; n++) begin
            f = FW'($urandom);
            if ($urandom_range(0, 4) == 0) run_partial(f, int'($urandom_range(1, FW - 1)));
            else run_frame(f, int'($urandom_range(0, TOUT + 2)), DW'($urandom),
                           int'($urandom_range(0, 4)), -1);
        end

        repeat (3) tick(1'b1, 1'b0, 1'b0, '0);
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'(0));
        chk("miso_queue_drained", 32'(miso_q.size()), 32'(0));
`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
        chk("err_cnt", 32'(err_cnt), 32'((err_exp > 255) ? 255 : err_exp));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
